// File: rtl/conv_pkg.sv
// Shared convolution datapath types and default sizes.
package conv_pkg;
    localparam int PIX_W       = 8;
    localparam int PROD_W      = 16;
    localparam int KERNEL_TAPS = 9;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [PIX_W-1:0]  pix_t;
endpackage

// File: rtl/conv_sat_shift.sv
// Right-shift a wide sum and saturate it to an unsigned 8-bit pixel.
module conv_sat_shift
    import conv_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] sum,
    output pix_t             pix
);
    logic [ACC_W-1:0] shifted;

    // Anything above 255 after scaling clips to full white.
    always_comb begin
        shifted = sum >> SHIFT;
        pix     = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
    end
endmodule

// File: rtl/conv_mac_accum.sv
// Window accumulator: sums KERNEL_TAPS products, holds the window result in a
// 1-entry valid/ready output register with full-throughput drain+load.
module conv_mac_accum #(
    parameter int KERNEL_TAPS = conv_pkg::KERNEL_TAPS,
    parameter int PROD_W      = conv_pkg::PROD_W,
    parameter int ACC_W       = 20,
    parameter int SHIFT       = 8,
    localparam int TW         = $clog2(KERNEL_TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PROD_W-1:0]   in_prod,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_acc,
    output conv_pkg::pix_t      out_pix,
    output logic [TW-1:0]       tap_idx
);
    import conv_pkg::*;

    if (ACC_W < PROD_W + $clog2(KERNEL_TAPS)) begin : g_bad_acc_w
        $error("conv_mac_accum: ACC_W too narrow for KERNEL_TAPS products");
    end
    if (KERNEL_TAPS < 2 || KERNEL_TAPS > 64) begin : g_bad_taps
        $error("conv_mac_accum: KERNEL_TAPS must be 2..64");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_bad_shift
        $error("conv_mac_accum: SHIFT must be 0..ACC_W-1");
    end

    localparam logic [TW-1:0] LAST_TAP = TW'(KERNEL_TAPS - 1);

    logic [TW-1:0]    tap_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    pix_t             sum_pix;
    logic             last_tap;
    logic             accept;
    logic             load;

    // Handshake: only the closing tap needs a free (or draining) output slot.
    always_comb begin
        last_tap = (tap_cnt == LAST_TAP);
        in_ready = !last_tap || !out_valid || out_ready;
        accept   = in_valid && in_ready && !clear;
        load     = accept && last_tap;
        // The first tap starts from zero so a stale acc never leaks in.
        sum      = ((tap_cnt == '0) ? '0 : acc) + ACC_W'(in_prod);
    end

    conv_sat_shift #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_sat (
        .sum (sum),
        .pix (sum_pix)
    );

    // Tap counter and running window sum; clear aborts the partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (clear) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (accept) begin
            acc     <= sum;
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        end
    end

    // Output register: load wins over drain so back-to-back windows stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_pix   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_acc   <= sum;
            out_pix   <= sum_pix;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign tap_idx = tap_cnt;
endmodule
